// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between A (ALU/load) and B (mult/div) with a starvation guard for B
module regfile_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_gnt,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_gnt,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              b_forced
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
   typedef enum logic {A_PRIO, FORCE_B} state_t;
   state_t            state, state_nxt;
   logic [CW-1:0]     starve_cnt, cnt_nxt;
   logic              b_lose, xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   // Grants depend only on requests and FSM state; B counts a loss only while A holds priority
   always_comb begin
      a_gnt     = ~reset & a_req & (state == A_PRIO | ~b_req);
      b_gnt     = ~reset & b_req & (state == FORCE_B | ~a_req);
      b_lose    = state == A_PRIO & a_req & b_req;
      cnt_nxt   = b_lose ? (starve_cnt == LIMIT ? LIMIT : starve_cnt + 1'b1) : '0;
      state_nxt = state == A_PRIO && cnt_nxt == LIMIT ? FORCE_B : A_PRIO;
      xfer      = a_gnt | b_gnt;
      sel_addr  = b_gnt ? b_addr : a_addr;
      sel_data  = b_gnt ? b_data : a_data;
   end
   // FSM, starvation counter and registered write port; index 0 is consumed without a write
   always_ff @(posedge CLK) begin
      if (reset) begin
         state      <= A_PRIO;
         starve_cnt <= '0;
         b_forced   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= cnt_nxt;
         b_forced   <= state_nxt == FORCE_B;
         wr_en      <= xfer & |sel_addr;
         if (xfer) begin
            wr_addr <= sel_addr;
            wr_data <= sel_data;
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a write-port scoreboard for the writeback arbiter
module tb_regfile_wb_arbiter;
   logic        CLK = 0;
   logic        reset = 1;
   logic        a_req = 0, b_req = 0;
   logic [4:0]  a_addr = 0, b_addr = 0;
   logic [31:0] a_data = 0, b_data = 0;
   logic        a_gnt, b_gnt, wr_en, b_forced;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   int          checks = 0, errors = 0;
   logic [36:0] exp_q[$];

   regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
      .CLK(CLK), .reset(reset),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .b_forced(b_forced)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
      end
   endtask

   // one cycle: drive at negedge, check grants shortly after, queue the write it should cause
   task automatic step(input string nm, input logic r, input logic ar, input logic [4:0] aa,
                       input logic [31:0] ad, input logic br, input logic [4:0] ba,
                       input logic [31:0] bd, input logic ea, input logic eb, input logic ef);
      @(negedge CLK);
      reset = r; a_req = ar; a_addr = aa; a_data = ad; b_req = br; b_addr = ba; b_data = bd;
      #1;
      chk({nm, " a_gnt"}, {31'd0, a_gnt}, {31'd0, ea});
      chk({nm, " b_gnt"}, {31'd0, b_gnt}, {31'd0, eb});
      chk({nm, " b_forced"}, {31'd0, b_forced}, {31'd0, ef});
      if (ea && aa != 0) exp_q.push_back({aa, ad});
      if (eb && ba != 0) exp_q.push_back({ba, bd});
   endtask

   // monitor: every presented write must match the oldest expected write
   always @(negedge CLK) begin
      if (wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected write: addr %0d data %h, expected none", wr_addr, wr_data);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               errors++;
               $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                        wr_addr, wr_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not end, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // 1: reset held with a_req high
      step("rst0", 1, 1, 5'd3, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
      step("rst1", 1, 1, 5'd3, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
      chk("reset wr_en", {31'd0, wr_en}, 0);
      chk("reset wr_addr", {27'd0, wr_addr}, 0);
      chk("reset wr_data", wr_data, 0);
      step("post_rst", 0, 1, 5'd3, 32'h1234_5678, 0, 0, 0, 1, 0, 0);
      // 2: A alone
      step("a_only", 0, 1, 5'd5, 32'hFFFF_1111, 0, 0, 0, 1, 0, 0);
      // 3: B alone to index 0, no write expected
      step("b_idx0", 0, 0, 0, 0, 1, 5'd0, 32'h0000_0001, 0, 1, 0);
      step("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("idx0 wr_en", {31'd0, wr_en}, 0);
      // 4: contention, B forced after four losses
      for (int i = 0; i < 4; i++)
         step("contend", 0, 1, 5'd7, 32'hA000_0000 + i, 1, 5'd9, 32'hB000_0009, 1, 0, 0);
      step("force", 0, 1, 5'd7, 32'hA000_0004, 1, 5'd9, 32'hB000_0009, 0, 1, 1);
      step("after_force", 0, 1, 5'd7, 32'hA000_0004, 1, 5'd10, 32'hB000_000A, 1, 0, 0);
      step("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // 5: A toggling lets B in, no force
      for (int i = 0; i < 6; i++)
         if (i % 2 == 0) step("toggle_a", 0, 1, 5'd11, 32'hC000_0000 + i, 1, 5'd12, 32'hD000_0000 + i, 1, 0, 0);
         else step("toggle_b", 0, 0, 0, 0, 1, 5'd12, 32'hD000_0000 + i, 0, 1, 0);
      // B drops mid-starvation: counter clears, no force
      for (int i = 0; i < 3; i++)
         step("starve_a", 0, 1, 5'd13, 32'hE000_0000 + i, 1, 5'd14, 32'hE100_0000, 1, 0, 0);
      step("b_drop", 0, 1, 5'd13, 32'hE000_0003, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++)
         step("starve_b", 0, 1, 5'd13, 32'hE000_0010 + i, 1, 5'd14, 32'hE100_0000, 1, 0, 0);
      step("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // 6: reset mid-starvation with a pending A write
      for (int i = 0; i < 3; i++)
         step("pre_rst", 0, 1, 5'd15, 32'hF000_0000 + i, 1, 5'd16, 32'hF100_0000, 1, 0, 0);
      step("mid_rst", 1, 1, 5'd4, 32'hF001_0001, 1, 5'd16, 32'hF100_0000, 0, 0, 0);
      step("rst_rel", 0, 1, 5'd4, 32'hF001_0001, 1, 5'd16, 32'hF100_0000, 1, 0, 0);
      chk("mid_rst wr_en", {31'd0, wr_en}, 0);
      for (int i = 0; i < 3; i++)
         step("re_contend", 0, 1, 5'd17, 32'hF200_0000 + i, 1, 5'd16, 32'hF100_0000, 1, 0, 0);
      step("re_force", 0, 1, 5'd17, 32'hF200_0003, 1, 5'd16, 32'hF100_0000, 0, 1, 1);
      step("idle3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("idle4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("pending writes", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
